// File: rtl/vector_sweep_ctrl.sv
// Sweeps a stimulus vector over every N_WIDTH-bit value, lets each one settle,
// samples the single-bit DUT response and hands it out as a ready/valid record.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; dut_in parked at zero
// ST_SETTLE  | holding dut_in while the settle down-counter runs out
// ST_CAPTURE | latching dut_out and dut_in into the record registers
// ST_EMIT    | rec_valid high until the consumer accepts the record
// ST_DONE    | one-cycle done pulse after the all-ones vector is accepted
module vector_sweep_ctrl #(
    parameter int N_WIDTH = 5,
    parameter int SETTLE  = 1
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [N_WIDTH-1:0] dut_in,
    input  logic               dut_out,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [N_WIDTH-1:0] rec_vector,
    output logic               rec_bit,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH:0]   ones_count
);

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);
    localparam logic [N_WIDTH:0] ONES_MAX  = {1'b1, {N_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;

    logic start_sweep;
    logic settle_ld;
    logic clr_vec;
    logic inc_vec;
    logic capture;
    logic count_one;

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_sweep = 1'b0;
        settle_ld   = 1'b0;
        clr_vec     = 1'b0;
        inc_vec     = 1'b0;
        capture     = 1'b0;
        count_one   = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort is meaningless here, so a coincident start still wins
                if (start) begin
                    start_sweep = 1'b1;
                    settle_ld   = 1'b1;
                    clr_vec     = 1'b1;
                    state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    clr_vec   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (settle_cnt <= 8'd1) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    clr_vec   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    clr_vec   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (rec_ready) begin
                    count_one = rec_bit;
                    if (dut_in == '1) begin
                        state_nxt = ST_DONE;
                    end else begin
                        inc_vec   = 1'b1;
                        settle_ld = 1'b1;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                clr_vec   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                clr_vec   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            settle_cnt <= 8'd0;
            dut_in     <= '0;
            rec_vector <= '0;
            rec_bit    <= 1'b0;
            ones_count <= '0;
        end else begin
            if (settle_ld) begin
                settle_cnt <= SETTLE_LD;
            end else if (state == ST_SETTLE && settle_cnt != 8'd0) begin
                settle_cnt <= settle_cnt - 8'd1;
            end

            if (clr_vec) begin
                dut_in <= '0;
            end else if (inc_vec) begin
                dut_in <= dut_in + 1'b1;
            end

            if (start_sweep) begin
                ones_count <= '0;
            end else if (count_one && ones_count != ONES_MAX) begin
                ones_count <= ones_count + 1'b1;
            end

            if (capture) begin
                rec_bit    <= dut_out;
                rec_vector <= dut_in;
            end
        end
    end

    assign rec_valid = (state == ST_EMIT);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench: instance a (defaults, dut_out = dut_in[0]) and instance b
// (SETTLE=3, dut_out = parity of dut_in delayed by two clocks).
module tb_vector_sweep_ctrl;

    logic       ck = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;

    logic       start_a, abort_a, rec_ready_a;
    logic [4:0] dut_in_a, rec_vector_a;
    logic       dut_out_a, rec_valid_a, rec_bit_a, busy_a, done_a;
    logic [5:0] ones_a;

    logic       start_b, abort_b, rec_ready_b;
    logic [4:0] dut_in_b, rec_vector_b;
    logic       dut_out_b, rec_valid_b, rec_bit_b, busy_b, done_b;
    logic [5:0] ones_b;
    logic       par_d1 = 1'b0;
    logic       par_d2 = 1'b0;

    int vec_q_a[$];
    int bit_q_a[$];
    int vec_q_b[$];
    int bit_q_b[$];
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    assign dut_out_a = dut_in_a[0];
    always @(posedge ck) begin
        par_d1 <= ^dut_in_b;
        par_d2 <= par_d1;
    end
    assign dut_out_b = par_d2;

    vector_sweep_ctrl u_dut_a (
        .CK(ck), .reset(rst), .start(start_a), .abort(abort_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a),
        .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
        .rec_vector(rec_vector_a), .rec_bit(rec_bit_a),
        .busy(busy_a), .done(done_a), .ones_count(ones_a)
    );

    vector_sweep_ctrl #(.N_WIDTH(5), .SETTLE(3)) u_dut_b (
        .CK(ck), .reset(rst), .start(start_b), .abort(abort_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b),
        .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
        .rec_vector(rec_vector_b), .rec_bit(rec_bit_b),
        .busy(busy_b), .done(done_b), .ones_count(ones_b)
    );

    // a record is taken at the next rising edge when it is valid, ready and not aborted
    always @(negedge ck) begin
        if (rec_valid_a && rec_ready_a && !abort_a) begin
            vec_q_a.push_back(int'(rec_vector_a));
            bit_q_a.push_back(int'(rec_bit_a));
        end
        if (rec_valid_b && rec_ready_b && !abort_b) begin
            vec_q_b.push_back(int'(rec_vector_b));
            bit_q_b.push_back(int'(rec_bit_b));
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, output int dcyc);
        bit found = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (done_a) begin
                found = 1'b1;
                dcyc  = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        tick();
    endtask

    task automatic chk_sweep_a(input string tag);
        chk({tag, "_nrec"}, 32'(vec_q_a.size()), 32'd32);
        for (int i = 0; i < vec_q_a.size() && i < 32; i++) begin
            chk({tag, "_vec"}, 32'(vec_q_a[i]), 32'(i));
            chk({tag, "_bit"}, 32'(bit_q_a[i]), 32'(i % 2));
        end
        chk({tag, "_ones"}, 32'(ones_a), 32'd16);
        chk({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_idle_dut_in"}, 32'(dut_in_a), 32'd0);
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_valid"}, 32'(rec_valid_a), 32'd0);
        chk({tag, "_dut_in"}, 32'(dut_in_a), 32'd0);
        chk({tag, "_rec_vector"}, 32'(rec_vector_a), 32'd0);
        chk({tag, "_rec_bit"}, 32'(rec_bit_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_ones"}, 32'(ones_a), 32'd0);
    endtask

    initial begin
        int c0;
        int cd;
        int d0;
        bit found;

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; rec_ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; rec_ready_b = 1'b1;
        repeat (2) tick();
        chk_all_zero_a("reset");
        rst = 1'b0;
        tick();

        // full default sweep
        vec_q_a.delete(); bit_q_a.delete();
        d0 = done_cnt_a;
        pulse_start_a();
        c0 = cyc;
        chk("t1_busy_after_start", 32'(busy_a), 32'd1);
        tick();
        chk("t1_no_valid_early", 32'(rec_valid_a), 32'd0);
        wait_done_a("t1", cd);
        chk("t1_cycles", 32'(cd - c0), 32'd96);
        chk("t1_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        chk_sweep_a("t1");

        // backpressure on vector 3
        vec_q_a.delete(); bit_q_a.delete();
        pulse_start_a();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rec_valid_a && rec_vector_a == 5'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t2_reach_v3", 32'(found), 32'd1);
        rec_ready_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_valid", 32'(rec_valid_a), 32'd1);
            chk("t2_hold_vector", 32'(rec_vector_a), 32'd3);
            chk("t2_hold_bit", 32'(rec_bit_a), 32'd1);
            chk("t2_hold_dut_in", 32'(dut_in_a), 32'd3);
        end
        rec_ready_a = 1'b1;
        wait_done_a("t2", cd);
        chk_sweep_a("t2");

        // abort during EMIT of vector 10 with rec_ready high
        vec_q_a.delete(); bit_q_a.delete();
        d0 = done_cnt_a;
        pulse_start_a();
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rec_valid_a && rec_vector_a == 5'd10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_reach_v10", 32'(found), 32'd1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t3_busy", 32'(busy_a), 32'd0);
        chk("t3_valid", 32'(rec_valid_a), 32'd0);
        chk("t3_dut_in", 32'(dut_in_a), 32'd0);
        chk("t3_ones", 32'(ones_a), 32'd5);
        chk("t3_nrec", 32'(vec_q_a.size()), 32'd10);
        repeat (20) tick();
        chk("t3_no_done", 32'(done_cnt_a - d0), 32'd0);
        chk("t3_still_idle", 32'(busy_a), 32'd0);
        chk("t3_ones_kept", 32'(ones_a), 32'd5);

        // start while busy is ignored
        vec_q_a.delete(); bit_q_a.delete();
        d0 = done_cnt_a;
        pulse_start_a();
        c0 = cyc;
        repeat (10) tick();
        pulse_start_a();
        wait_done_a("t4", cd);
        chk("t4_cycles", 32'(cd - c0), 32'd96);
        chk("t4_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        chk_sweep_a("t4");

        // asynchronous reset mid-sweep
        pulse_start_a();
        repeat (40) tick();
        chk("t5_pre_busy", 32'(busy_a), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero_a("t5_async");
        tick();
        rst = 1'b0;
        tick();
        chk("t5_wait_idle", 32'(busy_a), 32'd0);

        // abort together with start in IDLE still starts
        vec_q_a.delete(); bit_q_a.delete();
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        c0 = cyc;
        chk("t5_abort_start_busy", 32'(busy_a), 32'd1);
        chk("t5_abort_start_dut_in", 32'(dut_in_a), 32'd0);
        wait_done_a("t5", cd);
        chk("t5_cycles", 32'(cd - c0), 32'd96);
        chk_sweep_a("t5");

        // SETTLE=3 with a two-cycle delayed parity response
        vec_q_b.delete(); bit_q_b.delete();
        d0 = done_cnt_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        c0 = cyc;
        found = 1'b0;
        cd = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (done_b) begin
                found = 1'b1;
                cd = cyc;
                break;
            end
        end
        tick();
        chk("t6_done_seen", 32'(found), 32'd1);
        chk("t6_cycles", 32'(cd - c0), 32'd160);
        chk("t6_done_pulses", 32'(done_cnt_b - d0), 32'd1);
        chk("t6_nrec", 32'(vec_q_b.size()), 32'd32);
        for (int i = 0; i < vec_q_b.size() && i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            chk("t6_vec", 32'(vec_q_b[i]), 32'(i));
            chk("t6_bit", 32'(bit_q_b[i]), 32'(^v));
        end
        chk("t6_ones", 32'(ones_b), 32'd16);
        chk("t6_idle", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
